cb_filter_multi: RTL and testbench
==================================

CB_FILTER_MULTI -- requirements
Module: cb_filter_multi

Interface
REQ-001 SHALL have parameter KHashes, default 3, number of hash functions per item.
REQ-002 SHALL have parameter HashWidth, default 6, bucket index width; bucket count 2**HashWidth.
REQ-003 SHALL have parameter HashRounds, default 1, permute/xor rounds per hash.
REQ-004 SHALL have parameter InpWidth, default 11, data item width.
REQ-005 SHALL have parameter BucketWidth, default 3, saturating counter width per bucket.
REQ-006 SHALL have parameter NumLookups, default 2, number of independent lookup ports.
REQ-007 SHALL have parameter Seeds, default package constant, array [KHashes] of cb_seed_t.
REQ-008 SHALL have ports: clk_i in 1 clock; rst_i in 1 reset. One clock; reset is synchronous and active-high.
REQ-009 SHALL have ports: look_data_i in NumLookups x InpWidth lookup items; look_valid_o out NumLookups hit flags.
REQ-010 SHALL have ports: incr_data_i in InpWidth, incr_valid_i in 1, incr_ready_o out 1; insert handshake.
REQ-011 SHALL have ports: decr_data_i in InpWidth, decr_valid_i in 1, decr_ready_o out 1; remove handshake.
REQ-012 SHALL have ports: clear_i in 1 start clear; clear_busy_o out 1 clear in progress.
REQ-013 SHALL have ports: filter_usage_o out HashWidth+1 nonzero-bucket count; filter_full_o, filter_empty_o, filter_error_o out 1 each.

Function
REQ-014 SHALL run FSM with states IDLE and CLEAR; IDLE->CLEAR on clear_i; CLEAR->IDLE after final bucket.
REQ-015 SHALL in CLEAR zero one bucket per cycle, index 0 up to 2**HashWidth-1; busy exactly 2**HashWidth cycles.
REQ-016 SHALL drive incr_ready_o = decr_ready_o = (state==IDLE); transfer only on valid&&ready.
REQ-017 SHALL ignore clear_i while already in CLEAR.
REQ-018 SHALL force look_valid_o to 0 for all ports while in CLEAR.
REQ-019 SHALL map each item to KHashes indices; each bucket changes at most once per operation even if indices collide.
REQ-020 SHALL update buckets on cycle of accepted handshake; new values visible from next cycle.
REQ-021 SHALL, for same-cycle incr and decr, apply per-bucket net delta (+1, -1, or 0); identical data yields no change.
REQ-022 SHALL saturate: increment at 2**BucketWidth-1 holds value and sets filter_error_o; decrement at 0 holds 0 and sets filter_error_o.
REQ-023 SHALL keep filter_error_o sticky until reset or clear completion.
REQ-024 SHALL assert look_valid_o[p] iff all KHashes buckets of look_data_i[p] are nonzero, evaluated on pre-update bucket state.
REQ-025 SHALL drive filter_usage_o = registered count of nonzero buckets; filter_full_o = usage==2**HashWidth; filter_empty_o = usage==0.

Reset
REQ-026 SHALL on rst_i at clk_i edge: all buckets 0, state IDLE, clear index 0, error 0.
REQ-027 SHALL after reset show: look_valid_o 0, usage 0, empty 1, full 0, error 0, busy 0, readies 1.
REQ-028 SHALL let rst_i mid-CLEAR abort the sweep and reach the full reset state in the same edge.

Configuration
REQ-029 SHALL use macro CB_FILTER_MULTI_LOOKUP_REG_EN.
REQ-030 SHALL with macro defined register look_valid_o: 1-cycle latency from look_data_i, reset 0, masked if CLEAR in sampling cycle.
REQ-031 SHALL without macro drive look_valid_o combinationally, 0-cycle latency.

Structure
REQ-032 SHALL take cb_seed_t from cb_filter_pkg; add constants for counter max and usage width there.
REQ-033 SHALL use one sub-module cbf_hash (InpWidth in, one-hot 2**HashWidth out, parametrised by seed and rounds), instantiated per hash per port.

Verification
REQ-034 SHALL cover reset: assert rst_i 5 cycles -> usage 0, empty 1, error 0, look_valid_o 2'b00.
REQ-035 SHALL cover insert/lookup: incr 11'h05A once -> next cycle look port0=11'h05A hit 1; usage in 1..3; decr 11'h05A -> port0 hit 0, empty 1.
REQ-036 SHALL cover saturation: incr 11'h123 eight times (BucketWidth 3) -> error 1 after 8th, buckets hold 7; seven decr -> hit 0.
REQ-037 SHALL cover simultaneous ops: incr and decr 11'h3FF same cycle -> usage unchanged, no error.
REQ-038 SHALL cover clear: 4 items inserted, clear_i one cycle -> busy 64 cycles, readies 0, hits 0; afterwards usage 0, empty 1, error 0.
REQ-039 SHALL cover rst_i at clear cycle 20 -> busy 0 next cycle, usage 0, readies 1.

Source files
------------

// File: rtl/cb_filter_pkg.sv
// Shared types and constants for the counting Bloom filter: hash seeds,
// controller states and derived-width helpers.
package cb_filter_pkg;

    typedef struct packed {
        logic [31:0] xor_mask;
        logic [4:0]  rot;
    } cb_seed_t;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } cb_state_e;

    localparam int unsigned DefaultKHashes     = 3;
    localparam int unsigned DefaultBucketWidth = 3;
    localparam int unsigned DefaultHashWidth   = 6;

    localparam cb_seed_t [DefaultKHashes-1:0] DefaultSeeds = {
        cb_seed_t'{xor_mask: 32'hC2B2_AE35, rot: 5'd19},
        cb_seed_t'{xor_mask: 32'h85EB_CA6B, rot: 5'd11},
        cb_seed_t'{xor_mask: 32'h9E37_79B9, rot: 5'd7}
    };

    // Largest value a saturating bucket counter can hold.
    function automatic int unsigned cb_cnt_max(input int unsigned bw);
        return (32'd1 << bw) - 32'd1;
    endfunction

    // Usage must be able to represent "every bucket nonzero".
    function automatic int unsigned cb_usage_width(input int unsigned hw);
        return hw + 32'd1;
    endfunction

    localparam int unsigned DefaultCntMax     = cb_cnt_max(DefaultBucketWidth);
    localparam int unsigned DefaultUsageWidth = cb_usage_width(DefaultHashWidth);

endpackage

// File: rtl/cbf_hash.sv
// Seeded xor/rotate/xorshift hash of one data item, folded down to a
// bucket index and presented one-hot over all buckets.
module cbf_hash
    import cb_filter_pkg::*;
#(
    parameter int unsigned InpWidth   = 11,
    parameter int unsigned HashWidth  = 6,
    parameter int unsigned HashRounds = 1,
    parameter cb_seed_t    Seed       = DefaultSeeds[0]
) (
    input  logic [InpWidth-1:0]       data_i,
    output logic [2**HashWidth-1:0]   onehot_o
);

    logic [31:0]          mix;
    logic [HashWidth-1:0] idx;

    always_comb begin
        mix = 32'(data_i);
        for (int unsigned r = 0; r < HashRounds; r++) begin
            mix = mix ^ Seed.xor_mask;
            mix = (mix << Seed.rot) | (mix >> (6'd32 - {1'b0, Seed.rot}));
            mix = mix ^ (mix >> 13) ^ (mix << 5);
        end
        // Fold all 32 mixed bits into the index so every input bit matters.
        idx = '0;
        for (int unsigned b = 0; b < 32; b++) begin
            idx[b % HashWidth] = idx[b % HashWidth] ^ mix[b];
        end
        onehot_o      = '0;
        onehot_o[idx] = 1'b1;
    end

endmodule

// File: rtl/cb_filter_multi.sv
// Counting Bloom filter with one insert port, one remove port, several lookup
// ports and a bucket-sweep clear. Macro CB_FILTER_MULTI_LOOKUP_REG_EN registers look_valid_o.
module cb_filter_multi
    import cb_filter_pkg::*;
#(
    parameter int unsigned KHashes     = 3,
    parameter int unsigned HashWidth   = 6,
    parameter int unsigned HashRounds  = 1,
    parameter int unsigned InpWidth    = 11,
    parameter int unsigned BucketWidth = 3,
    parameter int unsigned NumLookups  = 2,
    parameter cb_seed_t [KHashes-1:0] Seeds = DefaultSeeds
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NumLookups-1:0][InpWidth-1:0]  look_data_i,
    output logic [NumLookups-1:0]                look_valid_o,
    input  logic [InpWidth-1:0]                  incr_data_i,
    input  logic                                 incr_valid_i,
    output logic                                 incr_ready_o,
    input  logic [InpWidth-1:0]                  decr_data_i,
    input  logic                                 decr_valid_i,
    output logic                                 decr_ready_o,
    input  logic                                 clear_i,
    output logic                                 clear_busy_o,
    output logic [HashWidth:0]                   filter_usage_o,
    output logic                                 filter_full_o,
    output logic                                 filter_empty_o,
    output logic                                 filter_error_o
);

    localparam int unsigned NumBuckets = 2 ** HashWidth;
    localparam int unsigned UsageWidth = cb_usage_width(HashWidth);
    localparam logic [BucketWidth-1:0] CntMax = BucketWidth'(cb_cnt_max(BucketWidth));
    localparam logic [HashWidth-1:0]   LastIdx = HashWidth'(NumBuckets - 1);

    cb_state_e state_q, state_d;
    logic [HashWidth-1:0]   clr_idx_q, clr_idx_d;
    logic [BucketWidth-1:0] bucket_q [NumBuckets];
    logic [BucketWidth-1:0] bucket_d [NumBuckets];
    logic [UsageWidth-1:0]  usage_q, usage_d;
    logic                   err_q, err_d, err_set;
    logic                   clear_done;
    logic                   idle;

    logic [NumBuckets-1:0] incr_oh [KHashes];
    logic [NumBuckets-1:0] decr_oh [KHashes];
    logic [NumBuckets-1:0] look_oh [NumLookups][KHashes];
    logic [NumBuckets-1:0] incr_mask, decr_mask, nonzero;
    logic [NumLookups-1:0] look_valid_d;
    logic                  incr_fire, decr_fire;

    for (genvar k = 0; k < KHashes; k++) begin : g_hash
        cbf_hash #(
            .InpWidth  (InpWidth),
            .HashWidth (HashWidth),
            .HashRounds(HashRounds),
            .Seed      (Seeds[k])
        ) u_incr_hash (
            .data_i  (incr_data_i),
            .onehot_o(incr_oh[k])
        );

        cbf_hash #(
            .InpWidth  (InpWidth),
            .HashWidth (HashWidth),
            .HashRounds(HashRounds),
            .Seed      (Seeds[k])
        ) u_decr_hash (
            .data_i  (decr_data_i),
            .onehot_o(decr_oh[k])
        );

        for (genvar p = 0; p < NumLookups; p++) begin : g_port
            cbf_hash #(
                .InpWidth  (InpWidth),
                .HashWidth (HashWidth),
                .HashRounds(HashRounds),
                .Seed      (Seeds[k])
            ) u_look_hash (
                .data_i  (look_data_i[p]),
                .onehot_o(look_oh[p][k])
            );
        end
    end

    // ORing the one-hots makes colliding indices touch a bucket only once.
    always_comb begin
        incr_mask = '0;
        decr_mask = '0;
        for (int unsigned k = 0; k < KHashes; k++) begin
            incr_mask = incr_mask | incr_oh[k];
            decr_mask = decr_mask | decr_oh[k];
        end
    end

    always_comb begin
        for (int unsigned b = 0; b < NumBuckets; b++) begin
            nonzero[b] = (bucket_q[b] != '0);
        end
    end

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (clear_i)    state_d = ST_CLEAR;
            ST_CLEAR: if (clear_done) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        idle         = (state_q == ST_IDLE);
        incr_ready_o = idle;
        decr_ready_o = idle;
        clear_busy_o = (state_q == ST_CLEAR);
    end

    assign clear_done = (state_q == ST_CLEAR) && (clr_idx_q == LastIdx);
    assign clr_idx_d  = (state_q == ST_CLEAR) ? clr_idx_q + HashWidth'(1) : '0;
    assign incr_fire  = incr_valid_i && idle;
    assign decr_fire  = decr_valid_i && idle;

    // Same-cycle insert and remove of a bucket cancel to a net zero delta.
    always_comb begin
        bucket_d = bucket_q;
        err_set  = 1'b0;
        if (state_q == ST_CLEAR) begin
            bucket_d[clr_idx_q] = '0;
        end else begin
            for (int unsigned b = 0; b < NumBuckets; b++) begin
                if (incr_fire && incr_mask[b] && !(decr_fire && decr_mask[b])) begin
                    if (bucket_q[b] == CntMax) err_set = 1'b1;
                    else bucket_d[b] = bucket_q[b] + BucketWidth'(1);
                end else if (decr_fire && decr_mask[b] && !(incr_fire && incr_mask[b])) begin
                    if (bucket_q[b] == '0) err_set = 1'b1;
                    else bucket_d[b] = bucket_q[b] - BucketWidth'(1);
                end
            end
        end
    end

    always_comb begin
        usage_d = '0;
        for (int unsigned b = 0; b < NumBuckets; b++) begin
            usage_d = usage_d + UsageWidth'(bucket_d[b] != '0);
        end
    end

    assign err_d = clear_done ? 1'b0 : (err_q | err_set);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clr_idx_q <= '0;
            usage_q   <= '0;
            err_q     <= 1'b0;
            for (int unsigned b = 0; b < NumBuckets; b++) begin
                bucket_q[b] <= '0;
            end
        end else begin
            clr_idx_q <= clr_idx_d;
            usage_q   <= usage_d;
            err_q     <= err_d;
            bucket_q  <= bucket_d;
        end
    end

    // Lookups see the bucket state before this cycle's updates.
    always_comb begin
        for (int unsigned p = 0; p < NumLookups; p++) begin
            look_valid_d[p] = idle;
            for (int unsigned k = 0; k < KHashes; k++) begin
                look_valid_d[p] = look_valid_d[p] && |(look_oh[p][k] & nonzero);
            end
        end
    end

`ifdef CB_FILTER_MULTI_LOOKUP_REG_EN
    logic [NumLookups-1:0] look_valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            look_valid_q <= '0;
        end else begin
            look_valid_q <= look_valid_d;
        end
    end

    assign look_valid_o = look_valid_q;
`else
    assign look_valid_o = look_valid_d;
`endif

    assign filter_usage_o = usage_q;
    assign filter_full_o  = (usage_q == UsageWidth'(NumBuckets));
    assign filter_empty_o = (usage_q == '0);
    assign filter_error_o = err_q;

endmodule

// File: tb/tb_cb_filter_multi.sv
// Directed self-checking bench for cb_filter_multi (default parameters).
// Honours CB_FILTER_MULTI_LOOKUP_REG_EN by waiting one cycle for lookups.
module tb_cb_filter_multi;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0][10:0] look_data;
    logic [1:0]       look_valid;
    logic [10:0]      incr_data;
    logic             incr_valid;
    logic             incr_ready;
    logic [10:0]      decr_data;
    logic             decr_valid;
    logic             decr_ready;
    logic             clear;
    logic             clear_busy;
    logic [6:0]       usage;
    logic             full;
    logic             empty;
    logic             error;

    int errors = 0;
    int checks = 0;

    cb_filter_multi dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .look_data_i   (look_data),
        .look_valid_o  (look_valid),
        .incr_data_i   (incr_data),
        .incr_valid_i  (incr_valid),
        .incr_ready_o  (incr_ready),
        .decr_data_i   (decr_data),
        .decr_valid_i  (decr_valid),
        .decr_ready_o  (decr_ready),
        .clear_i       (clear),
        .clear_busy_o  (clear_busy),
        .filter_usage_o(usage),
        .filter_full_o (full),
        .filter_empty_o(empty),
        .filter_error_o(error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [10:0] d0, input logic [10:0] d1, output logic [1:0] hits);
        look_data[0] = d0;
        look_data[1] = d1;
`ifdef CB_FILTER_MULTI_LOOKUP_REG_EN
        tick();
`else
        #1;
`endif
        hits = look_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) tick();
        rst = 1'b0;
        checks++; if (usage !== 7'd0) begin errors++; $display("FAIL reset_usage got=%0d exp=0", usage); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", error); end
        checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", clear_busy); end
        checks++; if ({incr_ready, decr_ready} !== 2'b11) begin errors++; $display("FAIL reset_ready got=%b exp=11", {incr_ready, decr_ready}); end
        checks++; if (look_valid !== 2'b00) begin errors++; $display("FAIL reset_look got=%b exp=00", look_valid); end
    endtask

    task automatic test_insert_lookup();
        logic [1:0] h;
        incr_data = 11'h05A; incr_valid = 1'b1;
        tick();
        incr_valid = 1'b0;
        lookup(11'h05A, 11'h05A, h);
        checks++; if (h !== 2'b11) begin errors++; $display("FAIL insert_hit got=%b exp=11", h); end
        checks++; if (usage < 7'd1 || usage > 7'd3) begin errors++; $display("FAIL insert_usage got=%0d exp=1..3", usage); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL insert_empty got=%b exp=0", empty); end
        decr_data = 11'h05A; decr_valid = 1'b1;
        tick();
        decr_valid = 1'b0;
        lookup(11'h05A, 11'h05A, h);
        checks++; if (h !== 2'b00) begin errors++; $display("FAIL remove_hit got=%b exp=00", h); end
        checks++; if (empty !== 1'b1 || usage !== 7'd0) begin errors++; $display("FAIL remove_empty got=%b/%0d exp=1/0", empty, usage); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL remove_error got=%b exp=0", error); end
    endtask

    task automatic test_simultaneous();
        logic [1:0] h;
        incr_data = 11'h3FF; decr_data = 11'h3FF;
        incr_valid = 1'b1; decr_valid = 1'b1;
        tick();
        incr_valid = 1'b0; decr_valid = 1'b0;
        checks++; if (usage !== 7'd0) begin errors++; $display("FAIL simul_empty_usage got=%0d exp=0", usage); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL simul_empty_error got=%b exp=0", error); end
        incr_valid = 1'b1;
        tick();
        decr_valid = 1'b1;
        tick();
        incr_valid = 1'b0; decr_valid = 1'b0;
        lookup(11'h3FF, 11'h3FF, h);
        checks++; if (h !== 2'b11) begin errors++; $display("FAIL simul_hit got=%b exp=11", h); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL simul_error got=%b exp=0", error); end
        decr_valid = 1'b1;
        tick();
        decr_valid = 1'b0;
        checks++; if (empty !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL simul_final got=%b/%b exp=1/0", empty, error); end
    endtask

    task automatic test_saturation();
        logic [1:0] h;
        incr_data = 11'h123; incr_valid = 1'b1;
        repeat (7) tick();
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL sat7_error got=%b exp=0", error); end
        tick();
        incr_valid = 1'b0;
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL sat8_error got=%b exp=1", error); end
        lookup(11'h123, 11'h123, h);
        checks++; if (h !== 2'b11) begin errors++; $display("FAIL sat_hit got=%b exp=11", h); end
        decr_data = 11'h123; decr_valid = 1'b1;
        repeat (6) tick();
        decr_valid = 1'b0;
        lookup(11'h123, 11'h123, h);
        checks++; if (h !== 2'b11) begin errors++; $display("FAIL sat_dec6_hit got=%b exp=11", h); end
        decr_valid = 1'b1;
        tick();
        decr_valid = 1'b0;
        lookup(11'h123, 11'h123, h);
        checks++; if (h !== 2'b00) begin errors++; $display("FAIL sat_dec7_hit got=%b exp=00", h); end
        checks++; if (usage !== 7'd0) begin errors++; $display("FAIL sat_usage got=%0d exp=0", usage); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL sat_sticky got=%b exp=1", error); end
    endtask

    task automatic test_clear();
        logic [1:0] h;
        int n;
        logic [10:0] items [4] = '{11'h001, 11'h2A5, 11'h47C, 11'h6E3};
        incr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            incr_data = items[i];
            tick();
        end
        incr_valid = 1'b0;
        lookup(11'h001, 11'h6E3, h);
        checks++; if (h !== 2'b11) begin errors++; $display("FAIL clr_pre_hit got=%b exp=11", h); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL clr_pre_empty got=%b exp=0", empty); end
        look_data[0] = 11'h2A5; look_data[1] = 11'h47C;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n = 0;
        while (clear_busy === 1'b1 && n < 100) begin
            if (n == 0) begin
                checks++; if ({incr_ready, decr_ready} !== 2'b00) begin errors++; $display("FAIL clr_ready got=%b exp=00", {incr_ready, decr_ready}); end
            end
            if (n == 5) begin
                checks++; if (look_valid !== 2'b00) begin errors++; $display("FAIL clr_look got=%b exp=00", look_valid); end
            end
            clear = (n == 10);
            n++;
            tick();
        end
        clear = 1'b0;
        checks++; if (n != 64) begin errors++; $display("FAIL clr_busy_cycles got=%0d exp=64", n); end
        checks++; if (usage !== 7'd0 || empty !== 1'b1) begin errors++; $display("FAIL clr_usage got=%0d/%b exp=0/1", usage, empty); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL clr_error got=%b exp=0", error); end
        checks++; if ({incr_ready, decr_ready} !== 2'b11) begin errors++; $display("FAIL clr_ready_after got=%b exp=11", {incr_ready, decr_ready}); end
        lookup(11'h2A5, 11'h47C, h);
        checks++; if (h !== 2'b00) begin errors++; $display("FAIL clr_post_hit got=%b exp=00", h); end
    endtask

    task automatic test_underflow();
        decr_data = 11'h0A5; decr_valid = 1'b1;
        tick();
        decr_valid = 1'b0;
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL under_error got=%b exp=1", error); end
        checks++; if (usage !== 7'd0) begin errors++; $display("FAIL under_usage got=%0d exp=0", usage); end
    endtask

    task automatic test_reset_mid_clear();
        logic [1:0] h;
        incr_data = 11'h155; incr_valid = 1'b1;
        tick();
        incr_valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (19) tick();
        checks++; if (clear_busy !== 1'b1) begin errors++; $display("FAIL rmc_busy_before got=%b exp=1", clear_busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL rmc_busy got=%b exp=0", clear_busy); end
        checks++; if (usage !== 7'd0 || empty !== 1'b1) begin errors++; $display("FAIL rmc_usage got=%0d/%b exp=0/1", usage, empty); end
        checks++; if ({incr_ready, decr_ready} !== 2'b11) begin errors++; $display("FAIL rmc_ready got=%b exp=11", {incr_ready, decr_ready}); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL rmc_error got=%b exp=0", error); end
        tick();
        checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL rmc_stay_idle got=%b exp=0", clear_busy); end
        lookup(11'h155, 11'h155, h);
        checks++; if (h !== 2'b00) begin errors++; $display("FAIL rmc_hit got=%b exp=00", h); end
    endtask

    initial begin
        rst = 1'b1;
        look_data = '0;
        incr_data = '0; incr_valid = 1'b0;
        decr_data = '0; decr_valid = 1'b0;
        clear = 1'b0;
        test_reset();
        test_insert_lookup();
        test_simultaneous();
        test_saturation();
        test_clear();
        test_underflow();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
